alu_issue_stage: RTL and testbench

- Front-end stage that feeds templatized_alu and collects its results.
- Buffers incoming operations in an input queue and issues at most one per cycle.
- Drives alu_a/alu_b in the issue cycle and alu_op one cycle later, to match the ALU's registered-operand / combinational-opcode timing.
- Tracks in-flight ops with a valid/tag pipeline, captures alu_out into a result queue, and presents results with a valid/ready handshake, tags preserved, strictly in order.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 52 +++++
 rtl/alu_issue_stage.sv | 125 ++++++++++++
 tb/tb_alu_issue_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, ALU pipeline latency, and the
// opcode encoding understood by templatized_alu.
package alu_pkg;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 4;
  // Edges from operands presented to alu_out valid.
  localparam int ALU_LAT = 2;

  // Opcode groups: add (ADD/SUB), bool (AND/OR/XOR), shift (SLL/SRL/SRA).
  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7
  } alu_op_e;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, registered count, no bypass.
// Ports: clk/rst (sync, active-high); push_i/din_i write; pop_i advances the
// head; dout_o shows the head; full_o/empty_o/count_o status.
// The caller never pushes when full nor pops when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rp_q, rp_d, wp_q, wp_d;
  logic [AW:0]      cnt_q, cnt_d;

  always_comb begin
    rp_d  = rp_q + AW'(pop_i);
    wp_d  = wp_q + AW'(push_i);
    cnt_d = cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = mem_q[rp_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
endmodule

// File: rtl/alu_issue_stage.sv
// Front-end for templatized_alu: queues ops, issues one per cycle with
// operands in the issue cycle and opcode one cycle later, tracks in-flight
// ops with a v1/v2 tag pipe and returns results in order via valid/ready.
// Ports: in_* accept side; alu_a/alu_b/alu_op/alu_out ALU side;
// res_* result side; busy when anything is queued, in flight or unread.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter int IQ_DEPTH = 4,
  parameter int RQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              busy
);
  localparam int IQ_W = OP_W + 2*DATA_W + TAG_W;
  localparam int RQ_W = DATA_W + TAG_W;
  localparam int ICW  = $clog2(IQ_DEPTH) + 1;
  localparam int RCW  = $clog2(RQ_DEPTH) + 1;

  logic             iq_push, iq_pop, iq_full, iq_empty;
  logic [IQ_W-1:0]  iq_dout;
  logic [ICW-1:0]   iq_count;
  logic             rq_push, rq_pop, rq_full, rq_empty;
  logic [RQ_W-1:0]  rq_dout;
  logic [RCW-1:0]   rq_count;

  logic [OP_W-1:0]   h_op;
  logic [DATA_W-1:0] h_a, h_b;
  logic [TAG_W-1:0]  h_tag;

  logic             v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [RCW:0]     committed;
  logic             issue;

  assign {h_op, h_a, h_b, h_tag} = iq_dout;

  assign in_ready = !iq_full && !rst;
  assign iq_push  = in_valid && in_ready;

  // Every RQ slot is reserved at issue: queued results plus both pipe
  // stages. The counts are registered, so a pop frees a credit next cycle.
  assign committed = (RCW+1)'(rq_count) + (RCW+1)'(v1_q) + (RCW+1)'(v2_q);
  assign issue     = !rst && !iq_empty && !rq_full &&
                     (committed < (RCW+1)'(RQ_DEPTH));
  assign iq_pop    = issue;

  assign alu_a  = issue ? h_a : '0;
  assign alu_b  = issue ? h_b : '0;
  // Opcode trails operands by one cycle: ALU registers operands, not op.
  assign alu_op = rst ? '0 : op_q;

  always_comb begin
    v1_d   = issue;
    tag1_d = issue ? h_tag : tag1_q;
    op_d   = issue ? h_op  : op_q;
    v2_d   = v1_q;
    tag2_d = tag1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      op_q   <= '0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      op_q   <= op_d;
    end
  end

  // alu_out belongs to the op in stage 2 during this cycle.
  assign rq_push   = v2_q && !rst;
  assign res_valid = !rq_empty && !rst;
  assign rq_pop    = res_valid && res_ready;
  assign {res_data, res_tag} = rq_dout;

  assign busy = !rst && ((iq_count != '0) || v1_q || v2_q || !rq_empty);

  sync_fifo #(.WIDTH(IQ_W), .DEPTH(IQ_DEPTH)) u_iq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (iq_push),
    .pop_i   (iq_pop),
    .din_i   ({in_op, in_a, in_b, in_tag}),
    .dout_o  (iq_dout),
    .full_o  (iq_full),
    .empty_o (iq_empty),
    .count_o (iq_count)
  );

  sync_fifo #(.WIDTH(RQ_W), .DEPTH(RQ_DEPTH)) u_rq (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rq_push),
    .pop_i   (rq_pop),
    .din_i   ({alu_out, tag2_q}),
    .dout_o  (rq_dout),
    .full_o  (rq_full),
    .empty_o (rq_empty),
    .count_o (rq_count)
  );
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a behavioural ALU stands in for templatized_alu,
// and an in-order expected-result queue checks every returned result.
module tb_alu_issue_stage;
  import alu_pkg::*;
  localparam int TAG_W = 4, IQ_DEPTH = 4, RQ_DEPTH = 4;

  logic              clk = 1'b0, rst = 1'b1;
  logic              in_valid = 1'b0, in_ready;
  logic [OP_W-1:0]   in_op = '0;
  logic [DATA_W-1:0] in_a = '0, in_b = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out = '0;
  logic [OP_W-1:0]   alu_op;
  logic              res_valid, res_ready = 1'b0, busy;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;

  alu_issue_stage #(.TAG_W(TAG_W), .IQ_DEPTH(IQ_DEPTH), .RQ_DEPTH(RQ_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ref_alu(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] a, b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return DATA_W'($signed(a) >>> b[4:0]);
      default: return '0;
    endcase
  endfunction

  // Behavioural ALU: operands registered, opcode used combinationally one
  // cycle later, result registered -> two edges of latency.
  logic [DATA_W-1:0] aq = '0, bq = '0;
  always @(posedge clk) begin
    aq      <= alu_a;
    bq      <= alu_b;
    alu_out <= ref_alu(alu_op, aq, bq);
  end

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
    int                acc;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0, cyc_n = 0, n_acc = 0, n_pop = 0;
  bit lat_chk = 1'b0;
  logic [TAG_W-1:0] tag_ctr = '0;
  bit hold_v = 1'b0;
  logic [DATA_W+TAG_W-1:0] hold_val = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h (cycle %0d)", nm, got, want, cyc_n);
    end
  endtask

  // One cycle, entered and left at a negedge. DUT outputs depend only on
  // registered state, so sampling right after driving is safe.
  task automatic cyc(input bit iv, input bit rr, input logic [OP_W-1:0] op,
                     input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    exp_t e;
    in_valid = iv; in_op = op; in_a = a; in_b = b; in_tag = tag_ctr;
    res_ready = rr;
    if (res_valid) begin
      if (hold_v) chk("res_hold", {res_data, res_tag}, hold_val);
      if (exp_q.size() == 0) chk("spurious_res", 1, 0);
      else if (rr) begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e.d);
        chk("res_tag", res_tag, e.t);
        if (lat_chk) chk("latency", cyc_n - e.acc, 4);
        n_pop++;
      end
    end
    hold_v   = res_valid && !rr;
    hold_val = {res_data, res_tag};
    if (iv && in_ready) begin
      exp_q.push_back(exp_t'{ref_alu(op, a, b), tag_ctr, cyc_n});
      tag_ctr++;
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic rcyc(input bit iv, input bit rr);
    cyc(iv, rr, OP_W'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  task automatic do_rst(input int n);
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    hold_v = 1'b0;
    cyc_n++;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_res_valid", res_valid, 0);
    chk("post_rst_alu_op", alu_op, 0);
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  int a0, p0;

  initial begin
    @(negedge clk);
    do_rst(2);

    // Single op with exact cycle-by-cycle timing.
    lat_chk = 1'b1;
    tag_ctr = 4'd3;
    cyc(1, 1, ALU_ADD, 32'd5, 32'd7);
    chk("t1_alu_a", alu_a, 5);
    chk("t1_alu_b", alu_b, 7);
    chk("t1_busy", busy, 1);
    rcyc(0, 1);
    chk("t2_alu_op", alu_op, ALU_ADD);
    chk("t2_alu_a_idle", alu_a, 0);
    rcyc(0, 1);
    chk("t3_res_valid", res_valid, 0);
    rcyc(0, 1);
    chk("t4_res_valid", res_valid, 1);
    chk("t4_res_data", res_data, 12);
    chk("t4_res_tag", res_tag, 3);
    rcyc(0, 1);
    chk("t5_busy", busy, 0);

    // Back-to-back: one result per cycle at exactly accept+4.
    tag_ctr = '0; a0 = n_acc; p0 = n_pop;
    repeat (8) rcyc(1, 1);
    repeat (8) rcyc(0, 1);
    chk("b2b_acc", n_acc - a0, 8);
    chk("b2b_pop", n_pop - p0, 8);
    chk("b2b_empty", exp_q.size(), 0);

    // Backpressure: RQ fills (4), issue stalls, IQ fills (4).
    lat_chk = 1'b0; a0 = n_acc;
    repeat (10) rcyc(1, 0);
    repeat (4) rcyc(0, 0);
    chk("bp_acc", n_acc - a0, 8);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_res_valid", res_valid, 1);
    chk("bp_queued", exp_q.size(), 8);

    // One-cycle res_ready pulse while both queues are full.
    p0 = n_pop;
    rcyc(1, 1);
    repeat (5) rcyc(1, 0);
    chk("sim_pop", n_pop - p0, 1);
    chk("sim_acc", n_acc - a0, 9);
    chk("sim_queued", exp_q.size(), 8);
    chk("sim_in_ready", in_ready, 0);
    repeat (14) rcyc(0, 1);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_busy", busy, 0);

    // Reset with ops in flight: none of them may ever return.
    repeat (3) rcyc(1, 1);
    do_rst(1);
    p0 = n_pop;
    repeat (8) rcyc(0, 1);
    lat_chk = 1'b1;
    cyc(1, 1, ALU_SUB, 32'd100, 32'd1);
    repeat (5) rcyc(0, 1);
    chk("post_rst_pop", n_pop - p0, 1);

    // Alternating ADD / SLL: opcode must line up with its operands.
    p0 = n_pop;
    for (int i = 0; i < 16; i++)
      cyc(1, 1, (i % 2) ? ALU_SLL : ALU_ADD, $urandom, DATA_W'($urandom_range(0, 31)));
    repeat (8) rcyc(0, 1);
    chk("alt_pop", n_pop - p0, 16);

    // Random traffic with random backpressure.
    lat_chk = 1'b0;
    repeat (400) rcyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    repeat (20) rcyc(0, 1);
    chk("rand_empty", exp_q.size(), 0);
    chk("rand_busy", busy, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
